// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter that shares one AES-128 core among NREQ requesters.
// One job in flight; the response carries the owner ID, ciphertext and timeout flag.
module aes_job_arbiter #(
  parameter int NREQ    = 2,
  parameter int KW      = 128,
  parameter int TIMEOUT = 64
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*128-1:0]  req_pt_i,
  input  logic [NREQ*KW-1:0]   req_key_i,
  output logic [127:0]         aes_state_o,
  output logic [KW-1:0]        aes_key_o,
  output logic                 aes_start_o,
  input  logic [127:0]         aes_ct_i,
  input  logic                 aes_valid_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [1:0]           resp_id_o,
  output logic [127:0]         resp_ct_o,
  output logic                 resp_err_o,
  output logic                 busy_o,
  output logic [7:0]           err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [1:0]     last_r;
  logic [1:0]     grant_s;
  logic [1:0]     hi_idx_s;
  logic [1:0]     lo_idx_s;
  logic           hi_found_s;
  logic           lo_found_s;
  logic           grant_found_s;
  logic           accept_s;
  logic           done_s;
  logic           tmo_s;
  logic           v_r;
  logic [15:0]    cnt_r;
  logic [127:0]   pt_sel_s;
  logic [KW-1:0]  key_sel_s;

  // Rotating priority: lowest valid index above last wins, else lowest valid index overall.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = 2'd0;
    lo_idx_s   = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i] && (i > int'(last_r))) begin
        hi_found_s = 1'b1;
        hi_idx_s   = 2'(i);
      end else if (req_valid_i[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = 2'(i);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    grant_found_s = hi_found_s | lo_found_s;
    if (hi_found_s) begin
      grant_s = hi_idx_s;
    end else begin
      grant_s = lo_idx_s;
    end
  end

  always_comb begin
    pt_sel_s    = 128'd0;
    key_sel_s   = {KW{1'b0}};
    req_ready_o = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s == 2'(i)) begin
        pt_sel_s       = req_pt_i[128*i +: 128];
        key_sel_s      = req_key_i[KW*i +: KW];
        req_ready_o[i] = (state_r == IDLE) && grant_found_s && !wb_rst_i;
      end else begin
        req_ready_o[i] = 1'b0;
      end
    end
  end

  assign accept_s = (state_r == IDLE) && grant_found_s;
  // Only a fresh rising edge inside BUSY completes a job; a stale level never does.
  assign done_s   = (state_r == BUSY) && aes_valid_i && !v_r;
  assign tmo_s    = (state_r == BUSY) && !done_s && (cnt_r == 16'(TIMEOUT - 1));

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = START;
        else          state_s = IDLE;
      end
      START: state_s = BUSY;
      BUSY: begin
        if (done_s || tmo_s) state_s = RESP;
        else                 state_s = BUSY;
      end
      RESP: begin
        if (resp_ready_i) state_s = IDLE;
        else              state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Status outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      v_r          <= 1'b0;
      last_r       <= 2'(NREQ - 1);
      cnt_r        <= 16'd0;
      aes_state_o  <= 128'd0;
      aes_key_o    <= {KW{1'b0}};
      aes_start_o  <= 1'b0;
      busy_o       <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_id_o    <= 2'd0;
      resp_ct_o    <= 128'd0;
      resp_err_o   <= 1'b0;
      err_cnt_o    <= 8'd0;
    end else begin
      v_r          <= aes_valid_i;
      aes_start_o  <= (state_s == START);
      busy_o       <= (state_s != IDLE);
      resp_valid_o <= (state_s == RESP);
      if (accept_s) begin
        aes_state_o <= pt_sel_s;
        aes_key_o   <= key_sel_s;
        resp_id_o   <= grant_s;
        last_r      <= grant_s;
      end
      if (state_r == START) begin
        cnt_r <= 16'd0;
      end else if ((state_r == BUSY) && !done_s && !tmo_s) begin
        cnt_r <= cnt_r + 16'd1;
      end
      if (done_s) begin
        resp_ct_o  <= aes_ct_i;
        resp_err_o <= 1'b0;
      end else if (tmo_s) begin
        resp_ct_o  <= 128'd0;
        resp_err_o <= 1'b1;
        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter: table of job vectors, hand-written corner
// sequences, and randomized jobs checked against a cycle-count reference model.
module tb_aes_job_arbiter;
  localparam int NREQ    = 2;
  localparam int KW      = 128;
  localparam int TIMEOUT = 24;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_pt;
  logic [NREQ*KW-1:0]  req_key;
  logic [127:0]        aes_state;
  logic [KW-1:0]       aes_key;
  logic                aes_start;
  logic [127:0]        aes_ct;
  logic                aes_valid;
  logic                resp_valid;
  logic                resp_ready;
  logic [1:0]          resp_id;
  logic [127:0]        resp_ct;
  logic                resp_err;
  logic                busy;
  logic [7:0]          err_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  int last_m = NREQ - 1;
  int err_m  = 0;

  always #5 clk = ~clk;

  aes_job_arbiter #(.NREQ(NREQ), .KW(KW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_pt_i(req_pt), .req_key_i(req_key),
    .aes_state_o(aes_state), .aes_key_o(aes_key), .aes_start_o(aes_start),
    .aes_ct_i(aes_ct), .aes_valid_i(aes_valid),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_id_o(resp_id), .resp_ct_o(resp_ct), .resp_err_o(resp_err),
    .busy_o(busy), .err_cnt_o(err_cnt)
  );

  // Stand-in cipher: the real FIPS-197 answer for the known vector, a fixed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
  endfunction

  // Round-robin reference: first valid index searching upward from last+1, wrapping.
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Core model: start seen in cycle S -> valid raised in cycle S+lat (lat 0 = never).
  int           core_lat  = 20;
  bit           core_hold = 1'b0;
  int           core_cnt  = 0;
  bit           core_pend = 1'b0;
  logic [127:0] core_ct_next;
  initial begin
    aes_valid = 1'b0;
    aes_ct    = 128'd0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        core_pend = 1'b0;
        aes_valid = 1'b0;
      end else begin
        if (!core_hold) aes_valid = 1'b0;
        if (core_pend) begin
          core_cnt--;
          if (core_cnt == 1 && core_hold) aes_valid = 1'b0;
          if (core_cnt == 0) begin
            aes_valid = 1'b1;
            aes_ct    = core_ct_next;
            core_pend = 1'b0;
          end
        end
        if (aes_start && core_lat > 0) begin
          core_pend    = 1'b1;
          core_cnt     = core_lat;
          core_ct_next = core_fn(aes_state, aes_key);
        end
      end
    end
  end

  // Runs one job from acceptance to handshake; called mid-cycle with the DUT idle.
  task automatic run_job(input logic [NREQ-1:0] v, input int id, input int lat,
                         input bit err, input logic [127:0] ct, input int exp_lat,
                         input int rdelay);
    logic [NREQ-1:0] oh;
    int k;
    bit seen;
    oh = {NREQ{1'b0}};
    oh[id] = 1'b1;
    core_lat = lat;
    req_valid = v;
    #1;
    chk("ready_grant", 128'(req_ready), 128'(oh));
    chk("busy_idle", 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    req_valid = v & ~oh;
    @(negedge clk);
    chk("start_t1", 128'(aes_start), 128'd1);
    chk("busy_t1", 128'(busy), 128'd1);
    chk("aes_state", aes_state, req_pt[128*id +: 128]);
    chk("aes_key", aes_key, req_key[KW*id +: KW]);
    chk("ready_start", 128'(req_ready), 128'd0);
    k = 1;
    seen = 1'b0;
    while (!seen && k < exp_lat + 6) begin
      @(negedge clk);
      k++;
      if (resp_valid) begin
        seen = 1'b1;
      end else begin
        chk("no_start_busy", 128'(aes_start), 128'd0);
        chk("ready_busy", 128'(req_ready), 128'd0);
        chk("busy_busy", 128'(busy), 128'd1);
      end
    end
    chk("resp_seen", 128'(seen), 128'd1);
    chk("resp_latency", 128'(k), 128'(exp_lat));
    if (err && err_m < 255) err_m++;
    chk("resp_id", 128'(resp_id), 128'(id));
    chk("resp_ct", resp_ct, ct);
    chk("resp_err", 128'(resp_err), 128'(err));
    chk("err_cnt", 128'(err_cnt), 128'(err_m));
    for (int d = 0; d < rdelay; d++) begin
      @(negedge clk);
      chk("hold_valid", 128'(resp_valid), 128'd1);
      chk("hold_id", 128'(resp_id), 128'(id));
      chk("hold_ct", resp_ct, ct);
      chk("hold_err", 128'(resp_err), 128'(err));
      chk("ready_resp", 128'(req_ready), 128'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", 128'(resp_valid), 128'd0);
    chk("busy_drop", 128'(busy), 128'd0);
    last_m = id;
  endtask

  task automatic set_data();
    for (int i = 0; i < NREQ; i++) begin
      req_pt[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
      req_key[KW*i +: KW]  = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    int              lat;
    int              exp_id;
    bit              exp_err;
    int              exp_lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [NREQ-1:0] v;
    logic [127:0]    ect;
    int              id;
    int              lat;
    bit              terr;

    tbl[0] = '{2'b11,  5, 0, 1'b0,  7};
    tbl[1] = '{2'b11,  9, 1, 1'b0, 11};
    tbl[2] = '{2'b11,  3, 0, 1'b0,  5};
    tbl[3] = '{2'b11, 12, 1, 1'b0, 14};
    tbl[4] = '{2'b10,  6, 1, 1'b0,  8};
    tbl[5] = '{2'b01,  0, 0, 1'b1, 26};
    tbl[6] = '{2'b11, 24, 1, 1'b0, 26};
    tbl[7] = '{2'b11,  2, 0, 1'b0,  4};
    tbl[8] = '{2'b01,  0, 0, 1'b1, 26};

    rst        = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 1'b0;
    req_pt     = {NREQ*128{1'b0}};
    req_key    = {NREQ*KW{1'b0}};
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(req_ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_start", 128'(aes_start), 128'd0);
    chk("rst_resp_valid", 128'(resp_valid), 128'd0);
    chk("rst_state", aes_state, 128'd0);
    chk("rst_err_cnt", 128'(err_cnt), 128'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 9; t++) begin
      set_data();
      id  = tbl[t].exp_id;
      ect = tbl[t].exp_err ? 128'd0 : core_fn(req_pt[128*id +: 128], req_key[KW*id +: KW]);
      run_job(tbl[t].valid, id, tbl[t].lat, tbl[t].exp_err, ect, tbl[t].exp_lat, 0);
    end

    req_pt[127:0]  = FIPS_PT;
    req_key[127:0] = FIPS_KEY;
    run_job(2'b01, 0, 20, 1'b0, FIPS_CT, 22, 1);

    // Backpressure with the core leaving valid high between jobs.
    core_hold = 1'b1;
    set_data();
    run_job(2'b10, 1, 4, 1'b0, core_fn(req_pt[255:128], req_key[255:128]), 6, 5);
    set_data();
    run_job(2'b01, 0, 6, 1'b0, core_fn(req_pt[127:0], req_key[127:0]), 8, 5);
    core_hold = 1'b0;

    // Reset in the middle of a job that would otherwise time out.
    core_lat  = 0;
    req_valid = 2'b10;
    #1;
    chk("rst_job_grant", 128'(req_ready), 128'b10);
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_start", 128'(aes_start), 128'd0);
    chk("midrst_resp_valid", 128'(resp_valid), 128'd0);
    chk("midrst_ready", 128'(req_ready), 128'd0);
    chk("midrst_state", aes_state, 128'd0);
    chk("midrst_key", aes_key, 128'd0);
    chk("midrst_err_cnt", 128'(err_cnt), 128'd0);
    err_m  = 0;
    last_m = NREQ - 1;
    repeat (2) @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;
    for (int c = 0; c < TIMEOUT + 6; c++) begin
      @(negedge clk);
      chk("postrst_no_resp", 128'(resp_valid), 128'd0);
    end
    set_data();
    run_job(2'b11, 0, 5, 1'b0, core_fn(req_pt[127:0], req_key[127:0]), 7, 0);

    for (int j = 0; j < 40; j++) begin
      set_data();
      v = 2'($urandom_range(1, 3));
      id = rr_pick(last_m, v);
      lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(2, TIMEOUT));
      terr = (lat == 0);
      ect = terr ? 128'd0 : core_fn(req_pt[128*id +: 128], req_key[KW*id +: KW]);
      run_job(v, id, lat, terr, ect, terr ? TIMEOUT + 2 : lat + 2,
              int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/aes_job_arbiter.md
# aes_job_arbiter

Shares one AES-128 encryption core between up to four independent requesters. Each requester presents a plaintext and key on a valid/ready port. The block round-robin-grants one job at a time, captures its operands, pulses the core start, and waits for completion or a timeout. It then returns the ciphertext with the requester ID on a single response port. It sits between the per-client register front-ends and the shared AES core, so the core sees one stable operand set per start pulse.

## Interface

Parameters:
- NREQ, 2, number of requesters (legal range 2..4).
- KW, 128, key width in bits.
- TIMEOUT, 64, maximum BUSY cycles to wait for core completion (range 2..65535).

Ports:
- wb_clk_i  in  1  sole clock; all logic on the rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NREQ  per-requester job valid.
- req_ready_o  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_pt_i  in  NREQ*128  plaintexts; requester i occupies bits [128*i+127:128*i].
- req_key_i  in  NREQ*KW  keys; packed the same way.
- aes_state_o  out  128  plaintext to the core; registered.
- aes_key_o  out  KW  key to the core; registered.
- aes_start_o  out  1  one-cycle start pulse to the core.
- aes_ct_i  in  128  core ciphertext.
- aes_valid_i  in  1  core output valid, level or pulse.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response accept.
- resp_id_o  out  2  index of the requester that owns the response.
- resp_ct_o  out  128  ciphertext; zero on error.
- resp_err_o  out  1  1 = the job timed out.
- busy_o  out  1  high in any state other than IDLE.
- err_cnt_o  out  8  count of timeouts, saturating at 255.

## Operation

- State machine IDLE -> START -> BUSY -> RESP -> IDLE. Encoding is free.
- **IDLE**
  - grant = first set bit of req_valid_i, searching from index (last+1) mod NREQ and wrapping.
  - req_ready_o[grant] is high combinationally; all other bits are low.
  - On acceptance (valid & ready), register pt and key into aes_state_o / aes_key_o, store the ID, set last = grant, and go to START.
  - With no valid request, stay in IDLE.
- **START**
  - aes_start_o = 1 for exactly this cycle.
  - Clear the timeout counter and go to BUSY.
- **BUSY**
  - aes_valid_i is registered every cycle as v_r. A done event is a rising edge, aes_valid_i & ~v_r.
  - Only edges seen in BUSY count. A level already high at entry, or an edge during START, is ignored.
  - On a done event: capture aes_ct_i into resp_ct_o, set resp_err_o = 0, go to RESP.
  - Otherwise increment the counter. When counter == TIMEOUT-1 with no done event: resp_ct_o = 0, resp_err_o = 1, err_cnt_o += 1 (saturating), go to RESP.
  - If a done event and the final timeout cycle coincide, the done event wins.
- **RESP**
  - resp_valid_o = 1. resp_id_o, resp_ct_o and resp_err_o are held stable.
  - On resp_ready_i, go to IDLE.
  - No request is accepted in RESP.
- aes_state_o and aes_key_o change only on acceptance. They are stable from START through RESP.
- Requesters not granted see req_ready_o = 0. Their valid and data must be held by them; the block does not buffer them.
- A request that drops valid before being granted is simply never accepted.
- last resets to NREQ-1, so requester 0 has first priority after reset.

## Timing

- Reset (asynchronous, immediate):
  - State = IDLE.
  - All outputs are 0: req_ready_o, aes_start_o, aes_state_o, aes_key_o, resp_*, busy_o, err_cnt_o.
  - v_r = 0 and last = NREQ-1.
  - Reset mid-job abandons the job with no response. The requester's acceptance already happened.
- Acceptance in cycle T gives:
  - aes_start_o high in T+1.
  - BUSY from T+2.
- A done event in cycle C gives resp_valid_o from C+1. End-to-end latency is core latency + 2 cycles, plus response backpressure.
- Timeout: resp_valid_o with err = 1 appears TIMEOUT+2 cycles after acceptance.
- Response handshake in cycle R:
  - IDLE in R+1.
  - The earliest next acceptance is R+1, so there is one bubble cycle between jobs.
- busy_o is registered from state. It rises in T+1 and falls in R+1.
- Exactly one aes_start_o pulse per accepted job. It is never asserted in IDLE, BUSY or RESP.

## Test plan

- **Single job, FIPS-197 vector.** Requester 0: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f. The core model has latency 20.
  - -> start pulse at T+1.
  - -> resp_valid at T+22 with ct 69c4e0d86a7b0430d8cdb78070b4c55a, id 0, err 0.
- **Round-robin order.** NREQ=2, both requesters valid continuously for four jobs.
  - -> grants 0,1,0,1.
  - -> resp_id sequence 0,1,0,1.
  - -> exactly four start pulses.
- **Timeout.** TIMEOUT=8 and the core never asserts valid.
  - -> resp_valid at T+10 with err 1, ct 0.
  - -> err_cnt_o = 1.
  - -> next request is accepted after the handshake.
- **Backpressure and stale level.** Hold resp_ready_i low for 5 cycles; the core leaves aes_valid_i high between jobs.
  - -> response is held stable for all 5 cycles.
  - -> the second job waits for a fresh rising edge rather than completing immediately.
- **Reset mid-BUSY.** Assert wb_rst_i in cycle T+5.
  - -> all outputs are 0 in the same cycle.
  - -> no response is issued.
  - -> after release, requester 0 has priority.
- **Done on the final timeout cycle.** The done edge lands on counter == TIMEOUT-1.
  - -> err 0, correct ct.
  - -> err_cnt_o unchanged.
